// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: loads a WIDTH-bit pattern and shifts it out MSB-first,
// (repeat_cnt+1) times with GAP_LEN zero bits between repetitions, then pulses done.
module seq_pattern_gen #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             stop,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] rep_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  // bit_cnt indexes the bit currently on w; shreg holds the bits still to come.
  always_ff @(posedge clk) begin
    if (Reset) begin
      // NOTE: only control state and outputs are reset; the datapath registers are
      // always reloaded on the way into SHIFT/GAP, so they need no reset.
      state   <= IDLE;
      w       <= 1'b0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: outputs default to 0 each cycle and the case below overrides them;
      // with non-blocking assignments the last assignment in the block wins.
      w       <= 1'b0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (load && !stop) begin
              pattern <= data;
              shreg   <= {data[WIDTH-2:0], 1'b0};
              rep_cnt <= repeat_cnt;
              bit_cnt <= '0;
              w       <= data[WIDTH-1];
              w_valid <= 1'b1;
              busy    <= 1'b1;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              if (rep_cnt != '0) begin
                rep_cnt <= rep_cnt - 1'b1;
                bit_cnt <= '0;
                w_valid <= 1'b1;
                busy    <= 1'b1;
                if (GAP_LEN > 0) begin
                  gap_cnt <= '0;
                  state   <= GAP;
                end else begin
                  w     <= pattern[WIDTH-1];
                  shreg <= {pattern[WIDTH-2:0], 1'b0};
                end
              end else begin
                busy  <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              w       <= shreg[WIDTH-1];
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              w_valid <= 1'b1;
              busy    <= 1'b1;
            end
          end
          GAP: begin
            w_valid <= 1'b1;
            busy    <= 1'b1;
            if (gap_cnt == GAP_LAST) begin
              w     <= pattern[WIDTH-1];
              shreg <= {pattern[WIDTH-2:0], 1'b0};
              state <= SHIFT;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: two instances (GAP_LEN=0 and 2) share stimulus
// and are compared every cycle against a stream-queue model, plus literal burst checks.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       Reset, load, stop;
  logic [7:0] data;
  logic [3:0] rpt;
  logic       w0, wv0, b0, d0;
  logic       w2, wv2, b2, d2;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;
  int hits  = 0;
  logic [2:0] hist = 3'b000;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  logic rec_w [2][64];
  logic rec_v [2][64];
  logic rec_b [2][64];
  logic rec_d [2][64];

  always #5 clk = ~clk;

  seq_pattern_gen #(.WIDTH(8), .CNT_W(4), .GAP_LEN(0)) u0 (
    .clk(clk), .Reset(Reset), .load(load), .data(data), .repeat_cnt(rpt), .stop(stop),
    .w(w0), .w_valid(wv0), .busy(b0), .done(d0)
  );

  seq_pattern_gen #(.WIDTH(8), .CNT_W(4), .GAP_LEN(2)) u2 (
    .clk(clk), .Reset(Reset), .load(load), .data(data), .repeat_cnt(rpt), .stop(stop),
    .w(w2), .w_valid(wv2), .busy(b2), .done(d2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: on an accepted load, queue every cycle of the burst as {w,w_valid,busy,done};
  // the head of the queue is what the outputs must show in the current cycle.
  task automatic model_step(input int i, input int gap);
    logic [3:0] q[$];
    if (i == 0) q = q0; else q = q1;
    if (Reset) q.delete();
    else if (q.size() != 0) begin
      if (stop) q.delete();
      else void'(q.pop_front());
    end else if (load && !stop) begin
      for (int r = 0; r <= int'(rpt); r++) begin
        for (int b = 7; b >= 0; b--) q.push_back({data[b], 3'b110});
        if (r < int'(rpt)) for (int g = 0; g < gap; g++) q.push_back(4'b0110);
      end
      q.push_back(4'b0011);
    end
    if (i == 0) q0 = q; else q1 = q;
  endtask

  always @(posedge clk) begin
    if (Reset) armed = 1'b1;
    model_step(0, 0);
    model_step(1, 2);
  end

  always @(negedge clk) begin
    logic [3:0] e0, e1;
    if (armed) begin
      e0 = (q0.size() != 0) ? q0[0] : 4'b0000;
      e1 = (q1.size() != 0) ? q1[0] : 4'b0000;
      check($sformatf("u0_stream@%0t", $time), 32'({w0, wv0, b0, d0}), 32'(e0));
      check($sformatf("u2_stream@%0t", $time), 32'({w2, wv2, b2, d2}), 32'(e1));
    end
  end

  // Downstream overlapping 101 detector on the GAP_LEN=0 instance.
  always @(negedge clk) begin
    if (wv0) begin
      hist = {hist[1:0], w0};
      if (hist == 3'b101) hits++;
    end else begin
      hist = 3'b000;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic record(input int c);
    rec_w[0][c] = w0; rec_v[0][c] = wv0; rec_b[0][c] = b0; rec_d[0][c] = d0;
    rec_w[1][c] = w2; rec_v[1][c] = wv2; rec_b[1][c] = b2; rec_d[1][c] = d2;
  endtask

  // Load d/r before edge 0, then record cycles 1..n; optional extra loads, stop, Reset.
  task automatic burst(input logic [7:0] d, input logic [3:0] r, input int n,
                       input int la, input int lb, input logic [7:0] ld,
                       input int stop_c, input int rst_c);
    hits = 0;
    for (int c = 0; c < 64; c++) begin
      for (int i = 0; i < 2; i++) begin
        rec_w[i][c] = 1'b0; rec_v[i][c] = 1'b0; rec_b[i][c] = 1'b0; rec_d[i][c] = 1'b0;
      end
    end
    data = d; rpt = r; load = 1'b1; stop = (stop_c == 0); Reset = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      record(c);
      load  = (c == la) || (c == lb);
      data  = load ? ld : d;
      stop  = (c == stop_c);
      Reset = (c == rst_c);
    end
    load = 1'b0; stop = 1'b0; Reset = 1'b0;
  endtask

  function automatic logic [31:0] bits_at(input int i, input int c, input int len);
    logic [31:0] v = '0;
    for (int k = 0; k < len; k++) v = {v[30:0], rec_w[i][c+k]};
    return v;
  endfunction

  function automatic int count_v(input int i, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (rec_v[i][c]) n++;
    return n;
  endfunction

  function automatic int count_d(input int i, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (rec_d[i][c]) n++;
    return n;
  endfunction

  function automatic int done_at(input int i);
    for (int c = 1; c < 64; c++) if (rec_d[i][c]) return c;
    return 0;
  endfunction

  initial begin
    Reset = 1'b1; load = 1'b0; stop = 1'b0; data = '0; rpt = '0;
    repeat (2) @(negedge clk);
    check("reset_u0", 32'({w0, wv0, b0, d0}), 0);
    check("reset_u2", 32'({w2, wv2, b2, d2}), 0);
    Reset = 1'b0;
    @(negedge clk);

    // Basic single burst
    burst(8'hA5, 4'd0, 11, -1, -1, 8'h00, -1, -1);
    check("basic_bits",   bits_at(0, 1, 8), 32'hA5);
    check("basic_valid",  count_v(0, 1, 11), 8);
    check("basic_done",   done_at(0), 9);
    check("basic_ndone",  count_d(0, 1, 11), 1);
    check("basic_v9",     32'(rec_v[0][9]), 0);
    check("basic_busy10", 32'(rec_b[0][10]), 0);
    check("basic_u2_bits", bits_at(1, 1, 8), 32'hA5);
    check("basic_u2_done", done_at(1), 9);

    // One repeat; GAP_LEN=2 inserts two zero bits
    burst(8'hA5, 4'd1, 21, -1, -1, 8'h00, -1, -1);
    check("gap_bits1",  bits_at(1, 1, 8), 32'hA5);
    check("gap_c9",     32'({rec_w[1][9], rec_v[1][9]}), 32'b01);
    check("gap_c10",    32'({rec_w[1][10], rec_v[1][10]}), 32'b01);
    check("gap_bits2",  bits_at(1, 11, 8), 32'hA5);
    check("gap_done",   done_at(1), 19);
    check("gap_ndone",  count_d(1, 1, 21), 1);
    check("gap_valid",  count_v(1, 1, 21), 18);
    check("nogap_bits2", bits_at(0, 9, 8), 32'hA5);
    check("nogap_done", done_at(0), 17);

    // Back-to-back repeats
    burst(8'h80, 4'd2, 31, -1, -1, 8'h00, -1, -1);
    check("b2b_valid", count_v(0, 1, 31), 24);
    check("b2b_rep0",  bits_at(0, 1, 8), 32'h80);
    check("b2b_rep1",  bits_at(0, 9, 8), 32'h80);
    check("b2b_rep2",  bits_at(0, 17, 8), 32'h80);
    check("b2b_done",  done_at(0), 25);
    check("b2b_hits",  hits, 0);
    check("b2b_u2_done",  done_at(1), 29);
    check("b2b_u2_valid", count_v(1, 1, 31), 28);

    // Ignored load at cycle 4, stop at cycle 6, fresh load at cycle 8
    burst(8'hA5, 4'd0, 18, 4, 8, 8'hFF, 6, -1);
    check("stop_prefix", bits_at(0, 1, 6), 32'b101001);
    check("stop_c7",     32'({rec_v[0][7], rec_b[0][7]}), 0);
    check("stop_nodone", count_d(0, 1, 8), 0);
    check("fresh_busy9", 32'(rec_b[0][9]), 1);
    check("fresh_bits",  bits_at(0, 9, 8), 32'hFF);
    check("fresh_done",  done_at(0), 17);

    // Reset during a GAP cycle of the gapped instance
    burst(8'hA5, 4'd1, 14, -1, -1, 8'h00, -1, 9);
    check("rst_gap_c9",  32'({rec_v[1][9], rec_b[1][9]}), 32'b11);
    check("rst_c10_u2",  32'({rec_w[1][10], rec_v[1][10], rec_b[1][10], rec_d[1][10]}), 0);
    check("rst_nodone",  count_d(1, 1, 14), 0);
    check("rst_c10_u0",  32'(rec_b[0][10]), 0);

    // stop and load together in IDLE: nothing starts
    burst(8'hFF, 4'd0, 3, -1, -1, 8'h00, 0, -1);
    check("stopload_u0", count_v(0, 1, 3), 0);
    check("stopload_u2", count_v(1, 1, 3), 0);

    // Detector pattern 1010_1000: two overlapping 101 hits
    burst(8'hA8, 4'd0, 10, -1, -1, 8'h00, -1, -1);
    check("det_hits", hits, 2);
    check("det_done", done_at(0), 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
